// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the hazard/stall controller and the pipeline:
// hazard-detect inputs from IF/ID and ID/EX, and the stall/flush/freeze
// controls going back to the pipeline registers.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             IDEXMEMRead;
  logic [REG_W-1:0] IDEXRegRt;
  logic [REG_W-1:0] IFIDRegRs;
  logic [REG_W-1:0] IFIDRegRt;
  logic             IFIDUsesRt;
  logic             BranchTaken;
  logic             MemReady;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             MuxSel;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             Freeze;
  logic             Busy;
  logic [CNT_W-1:0] StallCount;

  // Pipeline side: supplies hazard information, consumes the controls.
  modport master (
    output IDEXMEMRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, IFIDUsesRt,
           BranchTaken, MemReady,
    input  PCWrite, IFIDWrite, MuxSel, IFIDFlush, IDEXFlush, Freeze, Busy,
           StallCount
  );

  // Controller side.
  modport slave (
    input  IDEXMEMRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, IFIDUsesRt,
           BranchTaken, MemReady,
    output PCWrite, IFIDWrite, MuxSel, IFIDFlush, IDEXFlush, Freeze, Busy,
           StallCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard and stall controller for the 5-stage MIPS pipeline.
// Inserts LOAD_LAT bubbles per load-use hazard, freezes the whole pipeline
// while data memory is busy, flushes on a taken branch and counts the
// cycles on which the PC was held.
module hazard_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave ctrl
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  // Bubbles still owed after the one that starts the stall.
  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             hit;
  logic             pc_write;
  logic             ifid_write;
  logic             mux_sel;
  logic             ifid_flush;
  logic             idex_flush;
  logic             freeze;
  logic [CNT_W-1:0] stall_count;

  // Saturating increment: the counter sticks at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Register $0 is hard-wired to zero, so a load into it is never a hazard.
  assign hit = ctrl.IDEXMEMRead && (ctrl.IDEXRegRt != '0) &&
               ((ctrl.IDEXRegRt == ctrl.IFIDRegRs) ||
                (ctrl.IFIDUsesRt && (ctrl.IDEXRegRt == ctrl.IFIDRegRt)));

  // State register and remaining-bubble counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: freeze holds everything, a taken branch cancels any stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!ctrl.MemReady) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end else if (ctrl.BranchTaken) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == IDLE) begin
      // A single-cycle load needs only the bubble issued while still IDLE.
      if (hit && (LOAD_LAT > 1)) begin
        state_nxt = STALL;
        cnt_nxt   = LAT_M1;
      end
    end else begin
      // The load has already left ID/EX, so hit is not looked at here.
      if (cnt == 4'd1) begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt   = cnt - 4'd1;
      end
    end
  end

  // Pipeline controls, resolved by priority: reset, freeze, branch, stall.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    mux_sel    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      mux_sel    = 1'b1;
    end else if (!ctrl.MemReady) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze     = 1'b1;
    end else if (ctrl.BranchTaken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state == STALL) || hit) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      mux_sel    = 1'b1;
    end
  end

  // Performance counter: one tick per cycle on which the PC was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_write) begin
      stall_count <= sat_inc(stall_count);
    end
  end

  assign ctrl.PCWrite    = pc_write;
  assign ctrl.IFIDWrite  = ifid_write;
  assign ctrl.MuxSel     = mux_sel;
  assign ctrl.IFIDFlush  = ifid_flush;
  assign ctrl.IDEXFlush  = idex_flush;
  assign ctrl.Freeze     = freeze;
  assign ctrl.Busy       = (state == STALL);
  assign ctrl.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share one directed stimulus stream. A model tracks
// the number of bubbles still owed per instance and is compared against
// both DUTs every cycle; literal expectations pin the key scenarios.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic       s_mr;
  logic [4:0] s_rt;
  logic [4:0] s_rs;
  logic [4:0] s_irt;
  logic       s_uses;
  logic       s_br;
  logic       s_rdy;
  bit         cmp_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: bubbles still owed and expected stall counter, per instance.
  int owed [2] = '{0, 0};
  int scnt [2] = '{0, 0};

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) ifa ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  ifb ();

  assign ifa.IDEXMEMRead = s_mr;
  assign ifa.IDEXRegRt   = s_rt;
  assign ifa.IFIDRegRs   = s_rs;
  assign ifa.IFIDRegRt   = s_irt;
  assign ifa.IFIDUsesRt  = s_uses;
  assign ifa.BranchTaken = s_br;
  assign ifa.MemReady    = s_rdy;
  assign ifb.IDEXMEMRead = s_mr;
  assign ifb.IDEXRegRt   = s_rt;
  assign ifb.IFIDRegRs   = s_rs;
  assign ifb.IFIDRegRt   = s_irt;
  assign ifb.IFIDUsesRt  = s_uses;
  assign ifb.BranchTaken = s_br;
  assign ifb.MemReady    = s_rdy;

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ctrl(ifa)
  );
  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .ctrl(ifb)
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit hit_now();
    return s_mr && (s_rt != 5'd0) &&
           ((s_rt == s_rs) || (s_uses && (s_rt == s_irt)));
  endfunction

  // Expected {PCWrite, IFIDWrite, MuxSel, IFIDFlush, IDEXFlush, Freeze, Busy}.
  function automatic logic [6:0] exp_flags(input int k);
    logic busy;
    busy = (owed[k] > 0);
    if (reset)       return 7'b0010000;
    if (!s_rdy)      return {6'b000001, busy};
    if (s_br)        return {6'b110110, busy};
    if (busy || hit_now()) return {6'b001000, busy};
    return {6'b110000, busy};
  endfunction

  function automatic bit exp_pcw(input int k);
    logic [6:0] f;
    f = exp_flags(k);
    return f[6];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each edge: pay off owed bubbles, start new ones on a hit.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        owed[k] <= 0;
        scnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!exp_pcw(k) && (scnt[k] < cmax(k))) scnt[k] <= scnt[k] + 1;
        if (s_rdy) begin
          if (s_br)              owed[k] <= 0;
          else if (owed[k] > 0)  owed[k] <= owed[k] - 1;
          else if (hit_now())    owed[k] <= lat(k) - 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("flags_a", 32'({ifa.PCWrite, ifa.IFIDWrite, ifa.MuxSel, ifa.IFIDFlush,
                          ifa.IDEXFlush, ifa.Freeze, ifa.Busy}), 32'(exp_flags(0)));
      chk("count_a", 32'(ifa.StallCount), scnt[0]);
      chk("flags_b", 32'({ifb.PCWrite, ifb.IFIDWrite, ifb.MuxSel, ifb.IFIDFlush,
                          ifb.IDEXFlush, ifb.Freeze, ifb.Busy}), 32'(exp_flags(1)));
      chk("count_b", 32'(ifb.StallCount), scnt[1]);
    end
  end

  task automatic set_in(input bit mr, input int rt, input int rs, input int irt,
                        input bit uses, input bit br, input bit rdy);
    s_mr = mr; s_rt = 5'(rt); s_rs = 5'(rs); s_irt = 5'(irt);
    s_uses = uses; s_br = br; s_rdy = rdy;
  endtask

  // Present one cycle of inputs just after the edge, return mid-cycle.
  task automatic apply(input bit mr, input int rt, input int rs, input int irt,
                       input bit uses, input bit br, input bit rdy);
    @(posedge clk); #1;
    set_in(mr, rt, rs, irt, uses, br, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1);
    #2 reset = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    // reset held: PC held, bubble selected
    chk("rst_pcw",  ifa.PCWrite, 0);
    chk("rst_mux",  ifa.MuxSel, 1);
    chk("rst_busy", ifb.Busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // idle after reset
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("idle_pcw",  ifa.PCWrite, 1);
    chk("idle_ifid", ifa.IFIDWrite, 1);
    chk("idle_mux",  ifa.MuxSel, 0);
    chk("idle_busy", ifa.Busy, 0);
    chk("idle_cnt",  ifa.StallCount, 0);

    // single-cycle load-use on rs
    apply(1, 8, 8, 0, 0, 0, 1);
    chk("l1_pcw", ifa.PCWrite, 0);
    chk("l1_mux", ifa.MuxSel, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("l1_after_pcw", ifa.PCWrite, 1);
    chk("l1_after_mux", ifa.MuxSel, 0);
    chk("l1_cnt", ifa.StallCount, 1);

    // three-cycle load-use on rt; hit held during the stall is ignored
    do_reset();
    apply(1, 9, 3, 9, 1, 0, 1);
    chk("l3_c1_pcw",  ifb.PCWrite, 0);
    chk("l3_c1_mux",  ifb.MuxSel, 1);
    chk("l3_c1_busy", ifb.Busy, 0);
    apply(1, 9, 3, 9, 1, 0, 1);
    chk("l3_c2_busy", ifb.Busy, 1);
    chk("l3_c2_pcw",  ifb.PCWrite, 0);
    apply(1, 9, 3, 9, 1, 0, 1);
    chk("l3_c3_busy", ifb.Busy, 1);
    chk("l3_c3_mux",  ifb.MuxSel, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("l3_c4_pcw",  ifb.PCWrite, 1);
    chk("l3_c4_busy", ifb.Busy, 0);
    chk("l3_cnt",     ifb.StallCount, 3);
    // rt match without rt use, then a load into $0
    apply(1, 9, 3, 9, 0, 0, 1);
    chk("norte_pcw", ifb.PCWrite, 1);
    chk("norte_mux", ifb.MuxSel, 0);
    apply(1, 0, 0, 0, 1, 0, 1);
    chk("r0_pcw_b", ifb.PCWrite, 1);
    chk("r0_pcw_a", ifa.PCWrite, 1);
    apply(0, 0, 0, 0, 0, 0, 1);

    // freeze for two cycles in the middle of a stall
    do_reset();
    apply(1, 9, 9, 0, 0, 0, 1);
    apply(1, 9, 9, 0, 0, 0, 1);
    apply(1, 9, 9, 0, 0, 0, 0);
    chk("fz_freeze", ifb.Freeze, 1);
    chk("fz_mux",    ifb.MuxSel, 0);
    chk("fz_busy",   ifb.Busy, 1);
    apply(1, 9, 9, 0, 0, 0, 0);
    chk("fz2_freeze", ifb.Freeze, 1);
    apply(1, 9, 9, 0, 0, 0, 1);
    chk("fz_b3_mux",    ifb.MuxSel, 1);
    chk("fz_b3_freeze", ifb.Freeze, 0);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("fz_end_busy", ifb.Busy, 0);
    chk("fz_cnt",      ifb.StallCount, 5);
    chk("model_fz_cnt", scnt[1], 5);

    // taken branch on the second stall cycle, then freeze+branch
    do_reset();
    apply(1, 9, 3, 9, 1, 0, 1);
    apply(1, 9, 3, 9, 1, 1, 1);
    chk("br_ifidflush", ifb.IFIDFlush, 1);
    chk("br_idexflush", ifb.IDEXFlush, 1);
    chk("br_pcw",       ifb.PCWrite, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("br_next_busy", ifb.Busy, 0);
    chk("br_next_pcw",  ifb.PCWrite, 1);
    apply(0, 0, 0, 0, 0, 1, 0);
    chk("fzbr_freeze", ifb.Freeze, 1);
    chk("fzbr_flush",  ifb.IFIDFlush, 0);
    apply(0, 0, 0, 0, 0, 1, 1);
    chk("fzbr_late_flush", ifb.IDEXFlush, 1);
    chk("br_cnt",          ifb.StallCount, 2);

    // long freeze saturates the narrow counter; async reset clears it
    do_reset();
    repeat (20) apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("sat_cnt_b",   ifb.StallCount, 15);
    chk("sat_cnt_a",   ifa.StallCount, 20);
    chk("model_sat_b", scnt[1], 15);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt_b", ifb.StallCount, 0);
    chk("arst_cnt_a", ifa.StallCount, 0);
    chk("arst_pcw",   ifb.PCWrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("post_pcw", ifb.PCWrite, 1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised load-use hazard and pipeline-stall controller for the 5-stage MIPS pipeline. It sits between the IF/ID and ID/EX pipeline registers and drives PC write-enable, IF/ID write-enable, the bubble-insert control mux, and the flush signals. Unlike the single-cycle load-use detector, it supports:
- a configurable multi-cycle load latency, tracked by a stall counter FSM;
- a whole-pipeline freeze while data memory is not ready;
- branch-taken flushing;
- exclusion of register $0;
- a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register specifier width.
LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (legal range 1..15).
CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-high reset.
IDEXMEMRead  input  1  instruction in ID/EX is a load.
IDEXRegRt  input  REG_W  destination rt of the ID/EX load.
IFIDRegRs  input  REG_W  rs of the instruction in IF/ID.
IFIDRegRt  input  REG_W  rt of the instruction in IF/ID.
IFIDUsesRt  input  1  instruction in IF/ID reads rt as a source.
BranchTaken  input  1  branch resolved taken in EX.
MemReady  input  1  data memory ready; 0 requests a full freeze.
PCWrite  output  1  PC write enable.
IFIDWrite  output  1  IF/ID register write enable.
MuxSel  output  1  1 = zero ID/EX control signals (insert bubble).
IFIDFlush  output  1  clear IF/ID to a nop.
IDEXFlush  output  1  clear ID/EX to a nop.
Freeze  output  1  hold every pipeline register, including ID/EX and EX/MEM.
Busy  output  1  FSM is in STALL.
StallCount  output  CNT_W  cycles on which PCWrite was 0 (freeze or stall), saturating.

Behaviour:
- Hazard detect (combinational): hit = IDEXMEMRead & (IDEXRegRt != 0) & ((IDEXRegRt == IFIDRegRs) | (IFIDUsesRt & IDEXRegRt == IFIDRegRt)).
- FSM states: IDLE, STALL. A 4-bit counter cnt holds the remaining bubble cycles.
- Reset (asynchronous): state = IDLE, cnt = 0, StallCount = 0.
  - While reset is high: PCWrite = 0, IFIDWrite = 0, MuxSel = 1, IFIDFlush = 0, IDEXFlush = 0, Freeze = 0, Busy = 0.
  - Reset high in the middle of a stall aborts it immediately.
- Outputs are combinational from state and inputs, resolved by priority:
  1. Freeze (MemReady = 0): Freeze = 1, PCWrite = 0, IFIDWrite = 0, MuxSel = 0, flushes = 0. State and cnt hold.
  2. Branch (BranchTaken = 1): IFIDFlush = 1, IDEXFlush = 1, PCWrite = 1, IFIDWrite = 1, MuxSel = 0. Next state = IDLE, cnt = 0; any pending stall is cancelled.
  3. Stall (state == STALL, or IDLE & hit): PCWrite = 0, IFIDWrite = 0, MuxSel = 1.
  4. Otherwise: PCWrite = 1, IFIDWrite = 1, all other outputs 0.
- Transitions (only evaluated when not frozen and not branching):
  - IDLE & hit & LOAD_LAT == 1: stay IDLE. Exactly one bubble, then the load has moved past ID/EX.
  - IDLE & hit & LOAD_LAT > 1: go to STALL, cnt = LOAD_LAT - 1.
  - STALL: cnt decrements each cycle; when cnt == 1, return to IDLE. Total bubbles = LOAD_LAT.
  - In STALL, hit is ignored; the load has already left ID/EX.
- Freeze arriving during STALL holds cnt, so total bubbles are still exactly LOAD_LAT.
- Freeze and BranchTaken together: freeze wins. BranchTaken stays asserted because EX is held, and the flush happens on the first unfrozen cycle.
- Busy = (state == STALL).
- StallCount: increments on each clock edge where reset is low and PCWrite = 0. It saturates at 2^CNT_W - 1 and never wraps.
- No register-file write-through is assumed; forwarding is handled elsewhere.

Test Plan:
1. Reset high for 2 cycles, then release with no loads → PCWrite = 1, IFIDWrite = 1, MuxSel = 0, Busy = 0, StallCount = 0.
2. LOAD_LAT = 1: load with IDEXRegRt = 8, next instruction IFIDRegRs = 8 → exactly 1 cycle with PCWrite = 0 and MuxSel = 1; StallCount = 1.
3. LOAD_LAT = 3: IDEXRegRt = 9 equals IFIDRegRt = 9 with IFIDUsesRt = 1 → 3 consecutive bubble cycles, Busy = 1 on cycles 2–3; the same case with IFIDUsesRt = 0 produces no stall. IDEXRegRt = 0 = IFIDRegRs produces no stall.
4. LOAD_LAT = 3: MemReady = 0 for 2 cycles in the middle of the stall → Freeze = 1 and MuxSel = 0 on those cycles; 3 bubbles total; StallCount = 5.
5. LOAD_LAT = 3: BranchTaken = 1 on the second stall cycle → IFIDFlush = 1, IDEXFlush = 1, PCWrite = 1 on that cycle; next cycle Busy = 0.
6. CNT_W = 4, MemReady held at 0 for 20 cycles → StallCount reaches 15 and stays there; asserting reset then clears it to 0 asynchronously.
